acs_unit: RTL and testbench

Add-compare-select stage for the rate-1/2, K=3 (generators 7,5 octal) hard-decision Viterbi decoder. It sits directly upstream of the survivor path decoding unit (SPDu). Each accepted received symbol pair updates four path metrics, and the stage emits one decision bit per state on d0..d3, which drive SPDu's d0..d3 inputs, plus the current best state for traceback start.

---
 rtl/viterbi_pkg.sv | 39 +++
 rtl/acs_butterfly.sv | 40 ++++
 rtl/acs_unit.sv | 148 ++++++++++++++
 tb/tb_acs_unit.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/viterbi_pkg.sv
// ----------------------------------------------------------------------------
// viterbi_pkg
// Shared definitions for the rate-1/2, K=3 (7,5 octal) hard-decision Viterbi
// decoder: trellis constants, the encoder branch-output function and a
// saturating adder used by the path-metric arithmetic.
// ----------------------------------------------------------------------------
package viterbi_pkg;

    localparam int K       = 3;
    localparam int NSTATES = 1 << (K - 1);

    localparam logic [2:0] G0 = 3'b111;
    localparam logic [2:0] G1 = 3'b101;

    // Working width of the saturating adder; callers cast the result down to
    // their own metric width.
    localparam int SAT_W = 16;

    // Encoder output for a transition out of state s = {u[n-1], u[n-2]} with
    // new input bit u. Bit 1 pairs with G0, bit 0 with G1.
    function automatic logic [1:0] branch_out(input logic [1:0] s, input logic u);
        logic [2:0] taps;
        taps = {u, s};
        return {^(taps & G0), ^(taps & G1)};
    endfunction

    // a + b clamped to max_v; the extra sum bit catches carries out of SAT_W.
    function automatic logic [SAT_W-1:0] sat_add(input logic [SAT_W-1:0] a,
                                                 input logic [1:0]       b,
                                                 input logic [SAT_W-1:0] max_v);
        logic [SAT_W:0] sum;
        sum = {1'b0, a} + {{(SAT_W-1){1'b0}}, b};
        if (sum > {1'b0, max_v}) begin
            return max_v;
        end
        return sum[SAT_W-1:0];
    endfunction

endpackage

// File: rtl/acs_butterfly.sv
// ----------------------------------------------------------------------------
// acs_butterfly
// Add-compare-select for one next-state: adds each predecessor metric to its
// branch metric (saturating), keeps the smaller candidate and reports which
// predecessor won.
//
// Ports:
//   pm_p0_i  PM_W  metric of predecessor p0 = {s'[0],0}
//   pm_p1_i  PM_W  metric of predecessor p1 = {s'[0],1}
//   bm_p0_i  2     branch metric on the p0 -> s' transition
//   bm_p1_i  2     branch metric on the p1 -> s' transition
//   pm_o     PM_W  surviving (un-normalized) metric
//   dec_o    1     1 when the p1 candidate is strictly smaller
// ----------------------------------------------------------------------------
module acs_butterfly
    import viterbi_pkg::*;
#(
    parameter int PM_W = 4
) (
    input  logic [PM_W-1:0] pm_p0_i,
    input  logic [PM_W-1:0] pm_p1_i,
    input  logic [1:0]      bm_p0_i,
    input  logic [1:0]      bm_p1_i,
    output logic [PM_W-1:0] pm_o,
    output logic            dec_o
);

    localparam logic [SAT_W-1:0] PM_MAX = SAT_W'((1 << PM_W) - 1);

    logic [PM_W-1:0] cand0;
    logic [PM_W-1:0] cand1;

    assign cand0 = PM_W'(sat_add(SAT_W'(pm_p0_i), bm_p0_i, PM_MAX));
    assign cand1 = PM_W'(sat_add(SAT_W'(pm_p1_i), bm_p1_i, PM_MAX));

    // Ties (including two saturated candidates) keep the p0 path.
    assign dec_o = (cand1 < cand0);
    assign pm_o  = dec_o ? cand1 : cand0;

endmodule

// File: rtl/acs_unit.sv
// ----------------------------------------------------------------------------
// acs_unit
// Add-compare-select stage of the K=3 (7,5) hard-decision Viterbi decoder.
// Each accepted symbol pair updates the four path metrics in one cycle
// (branch metric -> add/saturate -> compare -> min4 -> normalize) and
// registers one decision bit per next-state plus the best state for the
// downstream survivor-path unit.
//
// Ports:
//   clk         clock, rising edge
//   reset       asynchronous active-high reset
//   start       frame start: reload initial metrics
//   in_valid    rx is valid this cycle
//   rx[1:0]     hard symbol; rx[1] <-> G0, rx[0] <-> G1
//   d0..d3      registered decision bit per next-state
//   best_state  registered argmin of the new metrics (lowest index on ties)
//   out_valid   registered; decisions/best_state updated this cycle
//   pm0..pm3    current normalized path metrics
// ----------------------------------------------------------------------------
module acs_unit
    import viterbi_pkg::*;
#(
    parameter int PM_W    = 4,
    parameter int INIT_PM = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            in_valid,
    input  logic [1:0]      rx,
    output logic            d0,
    output logic            d1,
    output logic            d2,
    output logic            d3,
    output logic [1:0]      best_state,
    output logic            out_valid,
    output logic [PM_W-1:0] pm0,
    output logic [PM_W-1:0] pm1,
    output logic [PM_W-1:0] pm2,
    output logic [PM_W-1:0] pm3
);

    localparam logic [PM_W-1:0] INIT_V = PM_W'(INIT_PM);

    function automatic logic [PM_W-1:0] init_metric(input int idx);
        return (idx == 0) ? '0 : INIT_V;
    endfunction

    function automatic logic [1:0] hamming2(input logic [1:0] a, input logic [1:0] b);
        logic [1:0] x;
        x = a ^ b;
        return {x[1] & x[0], x[1] ^ x[0]};
    endfunction

    logic [PM_W-1:0] pm_q    [NSTATES];
    logic [PM_W-1:0] pm_d    [NSTATES];
    logic [PM_W-1:0] base_pm [NSTATES];
    logic [PM_W-1:0] new_pm  [NSTATES];
    logic [NSTATES-1:0] dec_q;
    logic [NSTATES-1:0] dec_d;
    logic [1:0]      best_q;
    logic [1:0]      best_d;
    logic            vld_q;
    logic [PM_W-1:0] min_pm;

    // A symbol arriving with start is scored against the initial metrics,
    // so the stored ones are bypassed here rather than reloaded first.
    always_comb begin
        for (int i = 0; i < NSTATES; i++) begin
            base_pm[i] = start ? init_metric(i) : pm_q[i];
        end
    end

    // Next-state s' has predecessors {s'[0],0} and {s'[0],1}; the input bit
    // that drives either of them into s' is s'[1].
    for (genvar g = 0; g < NSTATES; g++) begin : g_acs
        localparam logic [1:0] SP = 2'(g);
        localparam logic [1:0] P0 = {SP[0], 1'b0};
        localparam logic [1:0] P1 = {SP[0], 1'b1};
        localparam logic       U  = SP[1];

        logic [1:0] bm0;
        logic [1:0] bm1;

        assign bm0 = hamming2(rx, branch_out(P0, U));
        assign bm1 = hamming2(rx, branch_out(P1, U));

        acs_butterfly #(.PM_W(PM_W)) u_bf (
            .pm_p0_i (base_pm[P0]),
            .pm_p1_i (base_pm[P1]),
            .bm_p0_i (bm0),
            .bm_p1_i (bm1),
            .pm_o    (new_pm[g]),
            .dec_o   (dec_d[g])
        );
    end

    // Strict less-than keeps the lowest index on ties.
    always_comb begin
        min_pm = new_pm[0];
        best_d = 2'd0;
        for (int i = 1; i < NSTATES; i++) begin
            if (new_pm[i] < min_pm) begin
                min_pm = new_pm[i];
                best_d = 2'(i);
            end
        end
        for (int i = 0; i < NSTATES; i++) begin
            pm_d[i] = new_pm[i] - min_pm;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NSTATES; i++) begin
                pm_q[i] <= init_metric(i);
            end
            dec_q  <= '0;
            best_q <= 2'd0;
            vld_q  <= 1'b0;
        end else begin
            vld_q <= in_valid;
            if (in_valid) begin
                for (int i = 0; i < NSTATES; i++) begin
                    pm_q[i] <= pm_d[i];
                end
                dec_q  <= dec_d;
                best_q <= best_d;
            end else if (start) begin
                for (int i = 0; i < NSTATES; i++) begin
                    pm_q[i] <= init_metric(i);
                end
            end
        end
    end

    assign d0         = dec_q[0];
    assign d1         = dec_q[1];
    assign d2         = dec_q[2];
    assign d3         = dec_q[3];
    assign best_state = best_q;
    assign out_valid  = vld_q;
    assign pm0        = pm_q[0];
    assign pm1        = pm_q[1];
    assign pm2        = pm_q[2];
    assign pm3        = pm_q[3];

endmodule

// File: tb/tb_acs_unit.sv
// ----------------------------------------------------------------------------
// tb_acs_unit
// Scoreboard bench for acs_unit. Two instances: the default one (PM_W=4,
// INIT_PM=8) and one with INIT_PM=15 so the first update saturates.
// Expected results are hand-computed trellis updates.
// ----------------------------------------------------------------------------
module tb_acs_unit;

    typedef struct packed {
        logic [3:0] d;      // {d3,d2,d1,d0}
        logic [1:0] best;
        logic [3:0] p0;
        logic [3:0] p1;
        logic [3:0] p2;
        logic [3:0] p3;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic [1:0] rx = 2'b00;
    logic       d0, d1, d2, d3, out_valid;
    logic [1:0] best_state;
    logic [3:0] pm0, pm1, pm2, pm3;

    logic       start2 = 1'b0;
    logic       in_valid2 = 1'b0;
    logic [1:0] rx2 = 2'b00;
    logic       e0, e1, e2, e3, out_valid2;
    logic [1:0] best_state2;
    logic [3:0] qm0, qm1, qm2, qm3;

    int checks = 0;
    int errors = 0;

    exp_t q1[$];
    exp_t q2[$];
    exp_t last1;

    always #5 clk = ~clk;

    acs_unit #(.PM_W(4), .INIT_PM(8)) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .rx(rx),
        .d0(d0), .d1(d1), .d2(d2), .d3(d3), .best_state(best_state),
        .out_valid(out_valid), .pm0(pm0), .pm1(pm1), .pm2(pm2), .pm3(pm3)
    );

    acs_unit #(.PM_W(4), .INIT_PM(15)) dut_sat (
        .clk(clk), .reset(reset), .start(start2), .in_valid(in_valid2), .rx(rx2),
        .d0(e0), .d1(e1), .d2(e2), .d3(e3), .best_state(best_state2),
        .out_valid(out_valid2), .pm0(qm0), .pm1(qm1), .pm2(qm2), .pm3(qm3)
    );

    function automatic exp_t mk(input logic [3:0] d, input logic [1:0] b,
                                input logic [3:0] a0, input logic [3:0] a1,
                                input logic [3:0] a2, input logic [3:0] a3);
        exp_t e;
        e.d = d; e.best = b; e.p0 = a0; e.p1 = a1; e.p2 = a2; e.p3 = a3;
        return e;
    endfunction

    function automatic exp_t act1();
        return mk({d3, d2, d1, d0}, best_state, pm0, pm1, pm2, pm3);
    endfunction

    function automatic exp_t act2();
        return mk({e3, e2, e1, e0}, best_state2, qm0, qm1, qm2, qm3);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic chk_out(input string name, input exp_t a, input exp_t e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got d=%b best=%0d pm={%0d,%0d,%0d,%0d} expected d=%b best=%0d pm={%0d,%0d,%0d,%0d}",
                     name, a.d, a.best, a.p0, a.p1, a.p2, a.p3,
                     e.d, e.best, e.p0, e.p1, e.p2, e.p3);
        end
    endtask

    // Monitors: pop one expectation per out_valid cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && out_valid) begin
                if (q1.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL dut_unexpected_out: got out_valid=1 expected no output");
                end else begin
                    e = q1.pop_front();
                    chk_out("dut_out", act1(), e);
                end
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && out_valid2) begin
                if (q2.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sat_unexpected_out: got out_valid=1 expected no output");
                end else begin
                    e = q2.pop_front();
                    chk_out("sat_out", act2(), e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic send1(input logic st, input logic [1:0] r, input exp_t e);
        start    = st;
        in_valid = 1'b1;
        rx       = r;
        q1.push_back(e);
        last1 = e;
        @(posedge clk);
        #1;
        start    = 1'b0;
        in_valid = 1'b0;
        rx       = 2'b00;
    endtask

    task automatic send2(input logic [1:0] r, input exp_t e);
        in_valid2 = 1'b1;
        rx2       = r;
        q2.push_back(e);
        @(posedge clk);
        #1;
        in_valid2 = 1'b0;
        rx2       = 2'b00;
    endtask

    task automatic idle_check(input string name);
        @(posedge clk);
        #1;
        chk({name, "_vld"}, 32'(out_valid), 32'd0);
        chk_out({name, "_hold"}, act1(), last1);
    endtask

    localparam exp_t RST = '{d: 4'b0000, best: 2'd0, p0: 4'd0, p1: 4'd8, p2: 4'd8, p3: 4'd8};

    exp_t a_exp, c_exp;
    exp_t nf[4];
    exp_t sat[10];

    initial begin
        a_exp = mk(4'b0000, 2'd0, 4'd0, 4'd9, 4'd2, 4'd9);
        c_exp = mk(4'b0000, 2'd2, 4'd2, 4'd3, 4'd0, 4'd3);
        nf[0] = mk(4'b0000, 2'd2, 4'd2, 4'd9, 4'd0, 4'd9);
        nf[1] = mk(4'b0000, 2'd1, 4'd3, 4'd0, 4'd3, 4'd2);
        nf[2] = mk(4'b1111, 2'd2, 4'd2, 4'd3, 4'd0, 4'd3);
        nf[3] = mk(4'b0000, 2'd3, 4'd3, 4'd2, 4'd3, 4'd0);
        sat[0] = nf[0];
        sat[1] = mk(4'b0000, 2'd1, 4'd3, 4'd0, 4'd1, 4'd0);
        sat[2] = mk(4'b1111, 2'd0, 4'd0, 4'd1, 4'd2, 4'd1);
        sat[3] = mk(4'b1011, 2'd2, 4'd1, 4'd2, 4'd0, 4'd2);
        sat[4] = mk(4'b0001, 2'd1, 4'd1, 4'd0, 4'd0, 4'd0);
        sat[5] = mk(4'b0001, 2'd0, 4'd0, 4'd1, 4'd1, 4'd1);
        sat[6] = mk(4'b0001, 2'd2, 4'd1, 4'd2, 4'd0, 4'd2);
        sat[7] = sat[4];
        sat[8] = sat[5];
        sat[9] = sat[6];

        // Reset values, while asserted and after release.
        repeat (2) @(posedge clk);
        #1;
        chk_out("reset_values", act1(), RST);
        chk("reset_vld", 32'(out_valid), 32'd0);
        reset = 1'b0;
        last1 = RST;
        idle_check("post_reset_idle");

        // First symbol after reset.
        send1(1'b0, 2'b00, a_exp);

        // Saturating instance: INIT_PM=15 forces clamped candidates.
        send2(2'b00, mk(4'b0000, 2'd0, 4'd0, 4'd15, 4'd2, 4'd15));
        send2(2'b00, mk(4'b0000, 2'd0, 4'd0, 4'd3, 4'd2, 4'd3));

        // Noise-free encoding of 1,0,1,1 (start with in_valid), gap-free.
        send1(1'b1, 2'b11, nf[0]);
        send1(1'b0, 2'b10, nf[1]);
        send1(1'b0, 2'b00, nf[2]);
        send1(1'b0, 2'b01, nf[3]);

        // Same sequence with a 3-cycle gap in the middle.
        send1(1'b1, 2'b11, nf[0]);
        send1(1'b0, 2'b10, nf[1]);
        idle_check("gap1");
        idle_check("gap2");
        idle_check("gap3");
        send1(1'b0, 2'b00, nf[2]);
        send1(1'b0, 2'b01, nf[3]);

        // Mid-frame start with a symbol ignores the stored metrics.
        send1(1'b1, 2'b00, a_exp);
        send1(1'b0, 2'b11, c_exp);

        // start alone reloads metrics; decisions and best_state hold.
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("start_only_vld", 32'(out_valid), 32'd0);
        chk_out("start_only_state", act1(),
                mk(c_exp.d, c_exp.best, 4'd0, 4'd8, 4'd8, 4'd8));
        last1 = mk(c_exp.d, c_exp.best, 4'd0, 4'd8, 4'd8, 4'd8);
        idle_check("start_only_idle");
        send1(1'b0, 2'b00, a_exp);

        // Ten rx=11 after start: metrics stay bounded and normalized.
        for (int i = 0; i < 10; i++) begin
            send1((i == 0) ? 1'b1 : 1'b0, 2'b11, sat[i]);
        end

        // Async reset between edges takes effect without a clock edge.
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk_out("async_reset_values", act1(), RST);
        chk("async_reset_vld", 32'(out_valid), 32'd0);
        #1;
        reset = 1'b0;
        send1(1'b0, 2'b00, a_exp);

        repeat (3) @(posedge clk);
        #1;
        chk("dut_queue_empty", 32'(q1.size()), 32'd0);
        chk("sat_queue_empty", 32'(q2.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
